// File: rtl/memport_pkg.sv
// rtl/memport_pkg.sv - shared mode encoding, mode enum and config width helper for memory_port_nconnect
package memport_pkg;

    localparam logic [1:0] ENC_OFF   = 2'b00;
    localparam logic [1:0] ENC_READ  = 2'b01;
    localparam logic [1:0] ENC_WRITE = 2'b10;
    localparam logic [1:0] ENC_ACCUM = 2'b11;

    typedef enum logic [1:0] {
        MODE_OFF   = ENC_OFF,
        MODE_READ  = ENC_READ,
        MODE_WRITE = ENC_WRITE,
        MODE_ACCUM = ENC_ACCUM
    } mode_t;

    // Chain holds MuxAddr, MuxData (SEL_W bits each) and the 2-bit Mode.
    function automatic int cfg_width(input int sel_w);
        return 2 * sel_w + 2;
    endfunction

endpackage

// File: rtl/memport_cfg_chain.sv
// rtl/memport_cfg_chain.sv - serial configuration shift chain with parallel readout
module memport_cfg_chain #(
    parameter int CFG_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             cfg_in_i,
    output logic             cfg_out_o,
    output logic [CFG_W-1:0] cfg_bits_o
);

    logic [CFG_W-1:0] chain_q;
    logic [CFG_W-1:0] chain_d;

    // New bits enter at the MSB; the LSB falls out onto the serial output.
    always_comb begin
        chain_d = chain_q;
        if (en_i) begin
            chain_d = {cfg_in_i, chain_q[CFG_W-1:1]};
        end
    end

    // Chain register, cleared to all zeros (Mode=OFF) on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign cfg_out_o  = chain_q[0];
    assign cfg_bits_o = chain_q;

endmodule

// File: rtl/memory_port_nconnect.sv
// rtl/memory_port_nconnect.sv - configurable read/write/accumulate memory port; MEMORY_PORT_NCONNECT_ACCUM_EN enables ACCUM mode
module memory_port_nconnect
    import memport_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     Config_Clock,
    input  logic                     Config_Reset,
    input  logic                     ConfigEnable,
    input  logic                     ConfigIn,
    output logic                     ConfigOut,
    input  logic [NUM_IN*DATA_W-1:0] in,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [DATA_W-1:0]        out,
    output logic                     out_valid
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SEL_W  = $clog2(NUM_IN);
    localparam int CFG_W  = cfg_width(SEL_W);

    logic [CFG_W-1:0]  cfg_bits;
    logic [SEL_W-1:0]  mux_addr;
    logic [SEL_W-1:0]  mux_data;
    mode_t             mode_eff;
    logic              addr_hit;
    logic              data_hit;
    logic              vld_addr;
    logic              vld_data;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] op_data;
    logic              req_read;
    logic              req_write;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    memport_cfg_chain #(
        .CFG_W (CFG_W)
    ) u_cfg_chain (
        .clk_i      (Config_Clock),
        .rst_ni     (Config_Reset),
        .en_i       (ConfigEnable),
        .cfg_in_i   (ConfigIn),
        .cfg_out_o  (ConfigOut),
        .cfg_bits_o (cfg_bits)
    );

    assign mux_addr = cfg_bits[CFG_W-1 -: SEL_W];
    assign mux_data = cfg_bits[2 +: SEL_W];

    // Operand muxes; a selector with no matching input leaves its hit flag low.
    always_comb begin
        addr_hit = 1'b0;
        data_hit = 1'b0;
        vld_addr = 1'b0;
        vld_data = 1'b0;
        addr     = '0;
        op_data  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (mux_addr == SEL_W'(i)) begin
                addr_hit = 1'b1;
                vld_addr = in_valid[i];
                addr     = in[i*DATA_W +: ADDR_W];
            end
            if (mux_data == SEL_W'(i)) begin
                data_hit = 1'b1;
                vld_data = in_valid[i];
                op_data  = in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Effective mode: out-of-range selectors, and ACCUM without the feature, act as OFF.
    always_comb begin
        mode_eff = mode_t'(cfg_bits[1:0]);
        if (!addr_hit || !data_hit) begin
            mode_eff = MODE_OFF;
        end
`ifdef MEMORY_PORT_NCONNECT_ACCUM_EN
`else
        if (mode_eff == MODE_ACCUM) begin
            mode_eff = MODE_OFF;
        end
`endif
    end

    assign req_read  = !ConfigEnable && (mode_eff == MODE_READ)  && vld_addr;
    assign req_write = !ConfigEnable && (mode_eff == MODE_WRITE) && vld_addr && vld_data;

`ifdef MEMORY_PORT_NCONNECT_ACCUM_EN
    logic              req_accum;
    logic              s2_valid_q;
    logic              s2_valid_d;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [ADDR_W-1:0] s2_addr_d;
    logic [DATA_W-1:0] s2_data_q;
    logic [DATA_W-1:0] s2_data_d;
    logic [DATA_W-1:0] s2_rd_q;
    logic [DATA_W-1:0] s2_rd_d;
    logic [DATA_W-1:0] s2_sum;

    assign req_accum = !ConfigEnable && (mode_eff == MODE_ACCUM) && vld_addr && vld_data;
    assign s2_sum    = s2_rd_q + s2_data_q;

    // Stage 1: capture the read, forwarding the stage-2 sum when it targets the same word.
    always_comb begin
        s2_valid_d = req_accum;
        s2_addr_d  = s2_addr_q;
        s2_data_d  = s2_data_q;
        s2_rd_d    = s2_rd_q;
        if (req_accum) begin
            s2_addr_d = addr;
            s2_data_d = op_data;
            s2_rd_d   = (s2_valid_q && (s2_addr_q == addr)) ? s2_sum : mem_q[addr];
        end
    end

    // Stage-2 registers; reset drops any pending accumulate write.
    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            s2_rd_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
            s2_rd_q    <= s2_rd_d;
        end
    end
`endif

    // Memory array (never reset): direct writes plus the accumulate write-back.
    always_ff @(posedge Config_Clock) begin
        if (req_write) begin
            mem_q[addr] <= op_data;
        end
`ifdef MEMORY_PORT_NCONNECT_ACCUM_EN
        if (s2_valid_q) begin
            mem_q[s2_addr_q] <= s2_sum;
        end
`endif
    end

    // Result selection: out holds unless a read or accumulate completes this cycle.
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (req_read) begin
            out_d       = mem_q[addr];
            out_valid_d = 1'b1;
        end
`ifdef MEMORY_PORT_NCONNECT_ACCUM_EN
        if (s2_valid_q && !ConfigEnable) begin
            out_d       = s2_sum;
            out_valid_d = 1'b1;
        end
`endif
    end

    // Output registers.
    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/memory_port_nconnect.md
MEMORY_PORT_NCONNECT -- requirements
Module: memory_port_nconnect

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of selectable operand inputs, 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: operand and memory word width.
REQ-003 SHALL have parameter DEPTH, default 256: memory words, power of two; ADDR_W = clog2(DEPTH), SEL_W = clog2(NUM_IN).
REQ-004 SHALL have port Config_Clock  in  1  sole clock; config shifting and datapath both act on its rising edge.
REQ-005 SHALL have port Config_Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port ConfigEnable  in  1  high = config chain shifts, datapath suspended.
REQ-007 SHALL have port ConfigIn  in  1  serial config data in.
REQ-008 SHALL have port ConfigOut  out  1  serial config data out, the last chain bit.
REQ-009 SHALL have port in  in  NUM_IN*DATA_W  operand i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port in_valid  in  NUM_IN  per-operand valid.
REQ-011 SHALL have port out  out  DATA_W  read or accumulate result.
REQ-012 SHALL have port out_valid  out  1  one-cycle pulse qualifying out.

Function
REQ-013 SHALL hold a config chain of CFG_W = 2*SEL_W+2 bits, in order MuxAddr[SEL_W], MuxData[SEL_W], Mode[2].
- On ConfigEnable=1, shift one bit per edge, ConfigIn entering the MuxAddr MSB.
- ConfigOut = Mode LSB.
REQ-014 SHALL decode Mode: 00 OFF, 01 READ, 10 WRITE, 11 ACCUM (OFF when the macro is absent).
- Out-of-range MuxAddr/MuxData (>= NUM_IN) SHALL behave as OFF.
REQ-015 SHALL fire a request on an edge where all of the following hold:
- ConfigEnable=0 and Mode!=OFF;
- in_valid[MuxAddr]=1;
- for WRITE/ACCUM, also in_valid[MuxData]=1.
REQ-016 SHALL use address = low ADDR_W bits of in[MuxAddr] and data = in[MuxData].
REQ-017 READ SHALL be synchronous, 1-cycle latency: out = mem[addr] and out_valid=1 in the cycle after the request.
REQ-018 WRITE SHALL update mem[addr] at the request edge; out_valid stays 0 and out holds its value.
REQ-019 Cycles without a request SHALL drive out_valid=0 and hold out.
REQ-020 ConfigEnable=1 SHALL suspend the datapath:
- no memory writes, no new requests, out_valid=0;
- any in-flight ACCUM stage-2 write still completes.

Reset
REQ-021 Config_Reset low SHALL immediately clear:
- all config bits (Mode=OFF), out=0, out_valid=0, ConfigOut=0;
- accumulate pipeline valid and forwarding state.
REQ-022 Memory array contents SHALL NOT be reset; a pending ACCUM write at reset assertion SHALL be discarded.
REQ-023 Release SHALL take effect at the first rising edge after deassertion; no request fires on that edge.

Configuration
REQ-024 Macro MEMORY_PORT_NCONNECT_ACCUM_EN defined: Mode 11 = ACCUM, a 2-stage read-add-write.
- Stage 1 reads mem[addr].
- Stage 2 writes sum = read+data mod 2^DATA_W, drives out=sum and out_valid=1.
- Latency 2 cycles; throughput 1 per cycle.
- Forwarding: when stage 1 addr equals the stage 2 addr, use the stage 2 sum instead of the array read.
REQ-025 Macro absent: no stage-2 logic synthesised; Mode 11 = OFF.

Structure
REQ-026 Shared package memport_pkg SHALL hold:
- the mode_t enum (OFF/READ/WRITE/ACCUM);
- the CFG_W computation function;
- the mode encoding constants.
REQ-027 The config chain SHALL be the single sub-module memport_cfg_chain (parameter CFG_W, ports clock/reset/enable/in/out/parallel bits); muxes and memory SHALL be inline.

Verification
REQ-028 Shift Mode=WRITE, MuxAddr=1, MuxData=2 -> ConfigOut reproduces the shifted-in stream delayed by CFG_W cycles; in1=5, in2=0xDEAD, both valid -> no out_valid. Then Mode=READ, in1=5 -> one cycle later out=0xDEAD, out_valid=1 for exactly 1 cycle.
REQ-029 READ with in_valid[MuxAddr]=0 for 3 cycles -> out_valid=0 and out unchanged throughout.
REQ-030 ACCUM (macro on), mem[7]=10, addr=7, data=3 on 3 consecutive cycles -> out=13,16,19 on cycles 2,3,4 (forwarding), then mem[7]=19.
REQ-031 ACCUM, mem[0]=0xFFFFFFFF, data=2 -> out=1 (wrap-around); macro off, Mode=11 -> no memory change, out_valid=0.
REQ-032 Reset asserted mid-ACCUM between stage 1 and stage 2 -> mem[addr] unchanged, out=0, out_valid=0, Mode=OFF after release.
REQ-033 ConfigEnable raised while WRITE requests are presented -> no memory write occurs during shifting.
